// File: rtl/tdc_pkg.sv
// Shared constants and sizing helpers for the TDC thermometer-to-binary path.
package tdc_pkg;

    localparam int N_BITS_DEF = 32;
    localparam int GROUP_W    = 8;

    // Binary width that holds 0..n without wrapping.
    function automatic int out_w_calc(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcnt8.sv
// Combinational 8-bit population count with a 4-bit result (0..8).
module popcnt8 (
    input  logic [7:0] data,
    output logic [3:0] cnt
);

    // Sum the eight bits.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, data[i]};
        end
    end

endmodule

// File: rtl/therm_to_bin_pipe.sv
// Three-stage thermometer-to-binary converter with optional bubble correction,
// bubble flag and a saturating bubble-error counter.
module therm_to_bin_pipe
    import tdc_pkg::*;
#(
    parameter  int N_BITS = N_BITS_DEF,
    parameter  int ERR_W  = 8,
    localparam int OUT_W  = out_w_calc(N_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [N_BITS-1:0] data_in,
    input  logic              bubble_fix,
    input  logic              err_clr,
    output logic              valid_out,
    output logic [OUT_W-1:0]  count,
    output logic              all_ones,
    output logic              all_zeros,
    output logic              bubble,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int N_GRP = N_BITS / GROUP_W;

    logic [N_BITS+1:0] ext_s;
    logic [N_BITS-1:0] maj_s;
    logic [N_BITS-1:0] corr_s;
    logic              bubble_raw_s;

    logic              v1_r;
    logic              bub1_r;
    logic [N_BITS-1:0] d1_r;

    logic [3:0]        grp_cnt_s [N_GRP];
    logic [3:0]        grp_r     [N_GRP];
    logic              v2_r;
    logic              bub2_r;

    logic [OUT_W-1:0]  sum_s;

    // Stage-1 combinational: majority repair and bubble detection on the raw word.
    always_comb begin
        // Pad below with a 1 (tap before the line) and above with a 0.
        ext_s = {1'b0, data_in, 1'b1};
        maj_s = '0;
        for (int i = 0; i < N_BITS; i++) begin
            maj_s[i] = (ext_s[i]   & ext_s[i+1]) |
                       (ext_s[i]   & ext_s[i+2]) |
                       (ext_s[i+1] & ext_s[i+2]);
        end
        if (bubble_fix) begin
            corr_s = maj_s;
        end else begin
            corr_s = data_in;
        end
        bubble_raw_s = |(data_in[N_BITS-1:1] & ~data_in[N_BITS-2:0]);
    end

    // Stage-1 registers: capture corrected word and raw bubble flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            bub1_r <= 1'b0;
            d1_r   <= '0;
        end else begin
            v1_r <= valid_in;
            if (valid_in) begin
                d1_r   <= corr_s;
                bub1_r <= bubble_raw_s;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_GRP; g++) begin : g_grp
            popcnt8 u_popcnt8 (
                .data (d1_r[g*GROUP_W +: GROUP_W]),
                .cnt  (grp_cnt_s[g])
            );
        end
    endgenerate

    // Stage-2 registers: per-group partial counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            bub2_r <= 1'b0;
            for (int i = 0; i < N_GRP; i++) begin
                grp_r[i] <= 4'd0;
            end
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                bub2_r <= bub1_r;
                for (int i = 0; i < N_GRP; i++) begin
                    grp_r[i] <= grp_cnt_s[i];
                end
            end
        end
    end

    // Stage-3 combinational: final sum at full output width.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N_GRP; i++) begin
            sum_s = sum_s + OUT_W'(grp_r[i]);
        end
    end

    // Stage-3 registers: outputs hold their last valid values between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            count     <= '0;
            all_ones  <= 1'b0;
            all_zeros <= 1'b0;
            bubble    <= 1'b0;
        end else begin
            valid_out <= v2_r;
            if (v2_r) begin
                count     <= sum_s;
                all_ones  <= (sum_s == OUT_W'(N_BITS));
                all_zeros <= (sum_s == '0);
                bubble    <= bub2_r;
            end
        end
    end

    // Error counter advances together with a bubble-flagged output; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (v2_r && bub2_r && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_therm_to_bin_pipe.sv
// Directed self-checking bench for therm_to_bin_pipe (N_BITS=32).
module tb_therm_to_bin_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic        bubble_fix;
    logic        err_clr;
    logic        valid_out;
    logic [5:0]  count;
    logic        all_ones;
    logic        all_zeros;
    logic        bubble;
    logic [7:0]  err_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;

    therm_to_bin_pipe #(.N_BITS(32), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .bubble_fix (bubble_fix),
        .err_clr    (err_clr),
        .valid_out  (valid_out),
        .count      (count),
        .all_ones   (all_ones),
        .all_zeros  (all_zeros),
        .bubble     (bubble),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " valid_out"}, int'(valid_out), 0);
        chk({tag, " count"},     int'(count),     0);
        chk({tag, " all_ones"},  int'(all_ones),  0);
        chk({tag, " all_zeros"}, int'(all_zeros), 0);
        chk({tag, " bubble"},    int'(bubble),    0);
        chk({tag, " err_cnt"},   int'(err_cnt),   0);
    endtask

    task automatic idle();
        valid_in = 1'b0;
        data_in  = 32'h0000_0000;
    endtask

    initial begin
        logic [32:0] one33;
        logic [32:0] w33;
        logic [4:0]  gap_v;
        logic [31:0] gap_d [5];
        int          gap_c [5];

        rst        = 1'b1;
        valid_in   = 1'b0;
        data_in    = 32'h0000_0000;
        bubble_fix = 1'b0;
        err_clr    = 1'b0;
        one33      = 33'd1;

        // Reset state
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b0;

        // Sweep k=0..32; sample i emerges two ticks after the tick that captures it.
        for (int i = 0; i <= 34; i++) begin
            if (i <= 32) begin
                w33      = (one33 << i) - 33'd1;
                valid_in = 1'b1;
                data_in  = w33[31:0];
            end else begin
                idle();
            end
            tick();
            if (i >= 2) begin
                chk("sweep valid_out", int'(valid_out), 1);
                chk("sweep count",     int'(count),     i - 2);
                chk("sweep all_zeros", int'(all_zeros), (i - 2 == 0)  ? 1 : 0);
                chk("sweep all_ones",  int'(all_ones),  (i - 2 == 32) ? 1 : 0);
                chk("sweep bubble",    int'(bubble),    0);
                chk("sweep err_cnt",   int'(err_cnt),   0);
            end
        end
        tick();
        chk("sweep drained valid_out", int'(valid_out), 0);
        chk("sweep hold count", int'(count), 32);

        // Bubble without correction
        valid_in = 1'b1; data_in = 32'h0000_00EF; bubble_fix = 1'b0;
        tick(); idle(); tick(); tick();
        chk("nofix valid_out", int'(valid_out), 1);
        chk("nofix count",     int'(count),     7);
        chk("nofix bubble",    int'(bubble),    1);
        chk("nofix err_cnt",   int'(err_cnt),   1);

        // Bubble with correction
        valid_in = 1'b1; data_in = 32'h0000_00EF; bubble_fix = 1'b1;
        tick(); idle(); bubble_fix = 1'b0; tick(); tick();
        chk("fix valid_out", int'(valid_out), 1);
        chk("fix count",     int'(count),     8);
        chk("fix bubble",    int'(bubble),    1);
        chk("fix err_cnt",   int'(err_cnt),   2);

        // 300 consecutive bubble samples saturate the counter
        for (int i = 0; i < 300; i++) begin
            valid_in = 1'b1; data_in = 32'h0000_00EF;
            tick();
        end
        idle(); tick(); tick();
        chk("sat err_cnt", int'(err_cnt), 255);
        chk("sat count",   int'(count),   7);
        tick(); tick();
        chk("sat hold err_cnt", int'(err_cnt), 255);

        // Clear coinciding with a bubble output
        valid_in = 1'b1; data_in = 32'h0000_00EF;
        tick(); idle(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr valid_out", int'(valid_out), 1);
        chk("clr bubble",    int'(bubble),    1);
        chk("clr err_cnt",   int'(err_cnt),   0);
        tick();
        chk("clr after err_cnt", int'(err_cnt), 0);

        // Reset while three samples are in flight
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = 32'h0000_00FF;
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("rst1");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_zero("rst_flush");
        end
        valid_in = 1'b1; data_in = 32'h0000_FFFF;
        tick(); idle(); tick();
        chk("post_rst early valid_out", int'(valid_out), 0);
        tick();
        chk("post_rst valid_out", int'(valid_out), 1);
        chk("post_rst count",     int'(count),     16);

        // Gapped stream 1,0,1,1,0
        gap_v    = 5'b01101;
        gap_d[0] = 32'h0000_0001; gap_c[0] = 1;
        gap_d[1] = 32'h0000_0000; gap_c[1] = 1;
        gap_d[2] = 32'h0000_0003; gap_c[2] = 2;
        gap_d[3] = 32'h7FFF_FFFF; gap_c[3] = 31;
        gap_d[4] = 32'h0000_0000; gap_c[4] = 31;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                valid_in = gap_v[i];
                data_in  = gap_d[i];
            end else begin
                idle();
            end
            tick();
            if (i >= 2) begin
                chk("gap valid_out", int'(valid_out), (i - 2 < 5) ? int'(gap_v[i-2]) : 0);
                if (i - 2 < 5) begin
                    chk("gap count", int'(count), gap_c[i-2]);
                end
            end
        end
        chk("gap err_cnt", int'(err_cnt), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/therm_to_bin_pipe.md
Name: therm_to_bin_pipe

Overview:
- Parametrised, pipelined thermometer-to-binary converter for the ADPLL TDC path.
- Converts an N_BITS thermometer word into a full-range binary count; the output width is sized so an all-ones word does not wrap.
- Optional bubble correction, a bubble/monotonicity error flag and a saturating error counter.
- Valid-tagged, fixed latency; sits between the TDC delay-line sampler and the phase detector/loop filter.

Parameters:
- N_BITS, 32, thermometer input width; must be a multiple of 8 and ≥ 8.
- OUT_W, $clog2(N_BITS+1), localparam: binary output width (6 for N_BITS=32).
- ERR_W, 8, width of the saturating bubble-error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  data_in is a new sample this cycle.
- data_in  in  N_BITS  thermometer code; bit 0 is the first delay tap and should be 1 first.
- bubble_fix  in  1  1 = apply 3-tap majority correction before counting; sampled with valid_in.
- err_clr  in  1  clears err_cnt.
- valid_out  out  1  count/flags are valid this cycle.
- count  out  OUT_W  number of ones in the (corrected) word, 0..N_BITS.
- all_ones  out  1  count == N_BITS (TDC range exceeded high).
- all_zeros  out  1  count == 0 (TDC range exceeded low).
- bubble  out  1  raw input was non-monotonic.
- err_cnt  out  ERR_W  saturating count of samples with bubble=1.

Behaviour:
- Reset (rst=1 at posedge): all pipeline registers, valid_out, count, all_ones, all_zeros, bubble and err_cnt go to 0. Reset dominates err_clr and valid_in. Samples in flight are discarded: valid_out stays 0 for 3 cycles after rst deasserts, unless valid_in is applied earlier.
- Pipeline: fixed 3-cycle latency from valid_in/data_in to valid_out/count. There is no backpressure, and one sample per cycle is accepted.
- Stage 1 (capture and correct):
  - Register data_in and bubble_fix when valid_in=1. When valid_in=0, the stage-1 valid bit clears and the data register may hold.
  - bubble_raw = OR over i=1..N_BITS-1 of (data_in[i] & ~data_in[i-1]), i.e. any 1 above a 0. Computed on raw input.
  - If bubble_fix=1, corrected bit c[i] = maj(d[i-1], d[i], d[i+1]), with d[-1]=1 and d[N_BITS]=0. Otherwise c = d.
- Stage 2 (partial sums): split c into N_BITS/8 groups of 8 and register a 4-bit popcount (0..8) per group. bubble and valid are pipelined alongside.
- Stage 3 (final sum): count = sum of the group popcounts at OUT_W width, with no truncation. all_ones = (count==N_BITS); all_zeros = (count==0). Register all outputs.
- Non-monotonic input without correction: count is still the exact popcount, not a leading-edge position. bubble=1 reports the defect.
- Outputs when valid_out=0: count and flags hold their last valid values. The bubble output is only meaningful when valid_out=1.
- err_cnt:
  - Increments by 1 in the cycle valid_out=1 and bubble=1, and saturates at 2^ERR_W-1 (no wrap).
  - err_clr=1 sets err_cnt to 0 and takes priority over a simultaneous increment.
- Back-to-back samples: each valid_in produces exactly one valid_out, in order, with no gaps or merges.
- Changing bubble_fix mid-stream affects only samples captured after the change.

Decomposition:
- Shared package tdc_pkg holds the N_BITS default, the OUT_W calculation function (clog2), and the GROUP_W=8 constant.
- One sub-module: popcnt8, an 8-bit combinational popcount with a 4-bit result, instantiated N_BITS/8 times in stage 2.
- Majority correction, bubble detect and the final adder live in the top module.

Test Plan (N_BITS=32, OUT_W=6, ERR_W=8):
- Sweep: after reset, drive valid_in with data_in = 2^k-1 for k=0..32 on consecutive cycles. Expect count=k three cycles later. all_zeros=1 only at k=0 and all_ones=1 only at k=32 (count=32, no wrap to 0). bubble=0 and err_cnt stays 0 throughout.
- Bubble, no fix: data_in=32'h0000_00EF (bits 0-3 and 5-7 set, bit 4 clear), bubble_fix=0. Expect count=7, bubble=1, err_cnt=1.
- Bubble, with fix: same word with bubble_fix=1. Expect count=8 (bit 4 repaired), bubble=1, err_cnt increments.
- Saturation and clear:
  - 300 consecutive bubble samples → err_cnt=255 and holds.
  - err_clr asserted in the same cycle as a bubble valid_out → err_cnt=0.
- Reset mid-flight: issue 3 samples, assert rst for 1 cycle while they are in the pipe. Expect valid_out=0 and all outputs 0 for the next 3 cycles. The next sample 0x0000_FFFF returns count=16 at latency 3.
- Gapped stream: valid_in pattern 1,0,1,1,0 with words 0x1, —, 0x3, 0x7FFF_FFFF. Expect the valid_out pattern to match, delayed 3 cycles, with counts 1, 2, 31.
